muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide instructions in the EX stage.
- Accepts one operation per start pulse and runs a radix-2 shift-add multiply or restoring divide over DATA_WIDTH cycles.
- Returns a registered result with a one-cycle done pulse.
- The hazard unit stalls the pipeline while busy is high; a branch/flush aborts any in-flight operation.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_seq.sv | 122 ++++++++++++
 tb/tb_muldiv_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and op classification helpers for the RV32M sequencer
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage and the multiply/divide sequencer
interface muldiv_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
);
    logic                  start;
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] MulDivResult;

    modport master (
        output start, op, SrcA, SrcB, flush,
        input  busy, done, MulDivResult
    );

    modport slave (
        input  start, op, SrcA, SrcB, flush,
        output busy, done, MulDivResult
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on {hi, lo} accumulator
module muldiv_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   operand_i,
    input  logic           div_i,
    output logic [2*W-1:0] acc_o
);
    logic [W:0]   sum;
    logic [W:0]   shl;
    logic [W-1:0] rem_n;
    logic         ge;

    // Multiply adds into the high half and shifts right; divide shifts left and trial-subtracts.
    always_comb begin
        sum   = {1'b0, acc_i[2*W-1:W]} + {1'b0, {W{acc_i[0]}} & operand_i};
        shl   = acc_i[2*W-1:W-1];
        ge    = shl >= {1'b0, operand_i};
        rem_n = shl[W-1:0] - operand_i;
        acc_o = div_i ? (ge ? {rem_n, acc_i[W-2:0], 1'b1} : {shl[W-1:0], acc_i[W-2:0], 1'b0})
                      : {sum, acc_i[W-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer with fast path, flush and sign fixup
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    muldiv_state_e       state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    muldiv_op_e          op_q, op_d, op_in;
    logic [OP_WIDTH-1:0] op_raw;
    logic                sa_q, sa_d, sb_q, sb_d, done_q, done_d;
    logic                sgn_a, sgn_b, div_zero, ovf, fast;
    logic [2*W-1:0]      acc_q, acc_d, acc_step, prod;
    logic [W-1:0]        opnd_q, opnd_d, res_q, res_d;
    logic [W-1:0]        mag_a, mag_b, fast_res, quo, rem, fix_res;

    assign op_raw   = bus.op;
    assign op_in    = muldiv_op_e'(op_raw);
    assign sgn_a    = is_signed_a(op_in) & bus.SrcA[W-1];
    assign sgn_b    = is_signed_b(op_in) & bus.SrcB[W-1];
    assign mag_a    = sgn_a ? -bus.SrcA : bus.SrcA;
    assign mag_b    = sgn_b ? -bus.SrcB : bus.SrcB;
    assign div_zero = is_div(op_in) && bus.SrcB == '0;
    assign ovf      = (op_in == OP_DIV || op_in == OP_REM) && bus.SrcA == {1'b1, {(W-1){1'b0}}} && &bus.SrcB;
    assign fast     = div_zero | ovf;
    assign fast_res = div_zero ? (is_rem(op_in) ? bus.SrcA : '1) : (is_rem(op_in) ? '0 : bus.SrcA);

    muldiv_step #(.W(W)) u_step (
        .acc_i    (acc_q),
        .operand_i(opnd_q),
        .div_i    (is_div(op_q)),
        .acc_o    (acc_step)
    );

    // Magnitudes were computed unsigned, so signs are restored only at the end.
    assign prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo     = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem     = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    assign fix_res = is_div(op_q) ? (is_rem(op_q) ? rem : quo)
                                  : (op_q == OP_MUL ? prod[W-1:0] : prod[2*W-1:W]);

    assign bus.busy         = state_q != IDLE;
    assign bus.done         = done_q;
    assign bus.MulDivResult = res_q;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    // Next state: capture in IDLE, iterate in CALC, fix up in FIX; flush wins everywhere.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        done_d  = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    op_d   = op_in;
                    sa_d   = sgn_a;
                    sb_d   = sgn_b;
                    acc_d  = {{W{1'b0}}, mag_a};
                    opnd_d = mag_b;
                    cnt_d  = '0;
                    if (fast) begin
                        res_d  = fast_res;
                        done_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) state_d = FIX;
                end
                FIX: begin
                    res_d   = fix_res;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and sequence checks of muldiv_seq with a result scoreboard
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct {
        muldiv_op_e     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   exp;
        bit             fast;
        string          name;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_WIDTH(W), .OP_WIDTH(3)) bus ();

    muldiv_seq #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    bit   prev_done = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(muldiv_op_e op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] exp, bit fast, string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.fast = fast; v.name = name;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon
        sb_t e;
        if (bus.done === 1'b1) begin
            n_done++;
            check("done_gap", {31'b0, prev_done}, 0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: result %h with no pending operation", bus.MulDivResult);
            end else begin
                e = sb.pop_front();
                check(e.name, bus.MulDivResult, e.exp);
            end
        end
        prev_done = bus.done;
    end

    task automatic drive(input muldiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        bit busy_ok;
        @(negedge clk);
        drive(v.op, v.a, v.b);
        sb.push_back(sb_t'{v.exp, v.name});
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy !== !v.fast) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({v.name, "_latency"}, n, v.fast ? 0 : W + 1);
        check({v.name, "_busy"}, {31'b0, busy_ok}, 1);
        check({v.name, "_busy_in_done"}, {31'b0, bus.busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;

        vecs.push_back(mk(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul_7_m3"));
        vecs.push_back(mk(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min_min"));
        vecs.push_back(mk(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu_max"));
        vecs.push_back(mk(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, "mulhsu_m1_2"));
        vecs.push_back(mk(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, "mulh_m1_m1"));
        vecs.push_back(mk(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, "div_m7_2"));
        vecs.push_back(mk(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, "rem_m7_2"));
        vecs.push_back(mk(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, "div_7_m2"));
        vecs.push_back(mk(OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        0, "rem_7_m2"));
        vecs.push_back(mk(OP_DIVU,   32'd100,      32'd7,        32'd14,       0, "divu_100_7"));
        vecs.push_back(mk(OP_REMU,   32'd100,      32'd7,        32'd2,        0, "remu_100_7"));
        vecs.push_back(mk(OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, "divu_max_1"));
        vecs.push_back(mk(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_5_0"));
        vecs.push_back(mk(OP_REM,    32'd5,        32'd0,        32'd5,        1, "rem_5_0"));
        vecs.push_back(mk(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf"));
        vecs.push_back(mk(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem_ovf"));

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_done", {31'b0, bus.done}, 0);
        check("rst_result", bus.MulDivResult, 0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Flush in CALC cycle 10 drops the operation and keeps the old result.
        @(negedge clk);
        drive(OP_MUL, 32'd5, 32'd6);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        d0 = n_done;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_calc_busy", {31'b0, bus.busy}, 0);
        check("flush_calc_result", bus.MulDivResult, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_calc_no_done", n_done, d0);
        run_op(mk(OP_MUL, 32'd3, 32'd4, 32'd12, 0, "mul_3_4"));

        // Flush in the FIX cycle suppresses completion.
        @(negedge clk);
        drive(OP_MUL, 32'd9, 32'd9);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W) @(negedge clk);
        check("fix_cycle_busy", {31'b0, bus.busy}, 1);
        bus.flush = 1'b1;
        d0 = n_done;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_fix_done", {31'b0, bus.done}, 0);
        check("flush_fix_busy", {31'b0, bus.busy}, 0);
        repeat (3) @(negedge clk);
        check("flush_fix_no_done", n_done, d0);
        check("flush_fix_result", bus.MulDivResult, 32'd12);

        // Start together with flush in IDLE is ignored, fast path included.
        @(negedge clk);
        drive(OP_DIVU, 32'd5, 32'd0);
        bus.flush = 1'b1;
        d0 = n_done;
        @(negedge clk);
        drive(OP_MUL, 32'd2, 32'd2);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", {31'b0, bus.busy}, 0);
        repeat (2) @(negedge clk);
        check("flush_start_no_done", n_done, d0);

        // Asynchronous reset mid-CALC clears outputs immediately.
        drive(OP_MUL, 32'd2, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_busy", {31'b0, bus.busy}, 0);
        check("areset_done", {31'b0, bus.done}, 0);
        check("areset_result", bus.MulDivResult, 0);
        @(negedge clk);
        reset = 1'b0;

        // Start while busy is ignored; start in the done cycle is accepted back-to-back.
        @(negedge clk);
        drive(OP_MUL, 32'd7, 32'hFFFFFFFD);
        sb.push_back(sb_t'{32'hFFFFFFEB, "b2b_first"});
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (n == 5) drive(OP_DIVU, 32'd5, 32'd0);
            else bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", n, W + 1);
        drive(OP_DIV, 32'hFFFFFFF9, 32'd2);
        sb.push_back(sb_t'{32'hFFFFFFFD, "b2b_second"});
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", n, W + 1);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
